// File: rtl/exe_forward_buffer.sv
// exe_forward_buffer: three-deep result history at ID/EXE with forwarded, registered EXE operands
module exe_forward_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              advance,
  input  logic              flush,
  input  logic              push_write,
  input  logic [4:0]        push_reg,
  input  logic              push_pending,
  input  logic              result_valid,
  input  logic [DATA_W-1:0] result_data,
  input  logic              fill_valid,
  input  logic [4:0]        fill_reg,
  input  logic [DATA_W-1:0] fill_data,
  input  logic [1:0]        sel_a,
  input  logic [1:0]        sel_b,
  input  logic [1:0]        sel_mem,
  input  logic [DATA_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_b,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic [DATA_W-1:0] store_data,
  output logic              op_valid,
  output logic              fwd_hazard,
  output logic [4:0]        hist_reg1,
  output logic [4:0]        hist_reg2,
  output logic [4:0]        hist_reg3
);
  logic [4:0]        sr [1:3];
  logic [DATA_W-1:0] sd [1:3];
  logic              sp [1:3];
  logic [4:0]        wr [0:3];
  logic [DATA_W-1:0] wd [0:3];
  logic              wp [0:3];
  logic              hit;
  logic [DATA_W-1:0] nxt_a, nxt_b, nxt_m;
  logic              nxt_h;
  logic              push_live;
  // history as seen after this edge's result and fill writes; entry 0 is a permanent empty slot so select 0 reads the register file
  always_comb begin
    wr[0] = '0;
    wd[0] = '0;
    wp[0] = 1'b0;
    hit = 1'b0;
    for (int k = 1; k < 4; k++) begin
      wr[k] = sr[k];
      wd[k] = sd[k];
      wp[k] = sp[k];
    end
    if (result_valid && sr[1] != '0) begin
      wd[1] = result_data;
      wp[1] = 1'b0;
    end
    for (int k = 1; k < 4; k++) begin
      if (!hit && fill_valid && sp[k] && sr[k] == fill_reg) begin
        wd[k] = fill_data;
        wp[k] = 1'b0;
        hit = 1'b1;
      end
    end
  end
  assign nxt_a = wr[sel_a] == '0 ? rf_a : wd[sel_a];
  assign nxt_b = wr[sel_b] == '0 ? rf_b : wd[sel_b];
  assign nxt_m = wr[sel_mem] == '0 ? rf_b : wd[sel_mem];
  assign nxt_h = wp[sel_a] | wp[sel_b] | wp[sel_mem];
  assign push_live = push_write && push_reg != '0;
  // history shift, write-back into slots and operand capture
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 1; k < 4; k++) begin
        sr[k] <= '0;
        sd[k] <= '0;
        sp[k] <= 1'b0;
      end
      operand_a <= '0;
      operand_b <= '0;
      store_data <= '0;
      op_valid <= 1'b0;
      fwd_hazard <= 1'b0;
    end else if (flush) begin
      for (int k = 1; k < 4; k++) begin
        sr[k] <= '0;
        sd[k] <= '0;
        sp[k] <= 1'b0;
      end
      op_valid <= 1'b0;
      fwd_hazard <= 1'b0;
    end else if (advance) begin
      operand_a <= nxt_a;
      operand_b <= nxt_b;
      store_data <= nxt_m;
      op_valid <= 1'b1;
      fwd_hazard <= nxt_h;
      for (int k = 2; k < 4; k++) begin
        sr[k] <= wr[k-1];
        sd[k] <= wd[k-1];
        sp[k] <= wp[k-1];
      end
      sr[1] <= push_live ? push_reg : 5'd0;
      sd[1] <= '0;
      sp[1] <= push_live && push_pending;
    end else begin
      for (int k = 1; k < 4; k++) begin
        sr[k] <= wr[k];
        sd[k] <= wd[k];
        sp[k] <= wp[k];
      end
    end
  end
  assign hist_reg1 = sr[1];
  assign hist_reg2 = sr[2];
  assign hist_reg3 = sr[3];
endmodule

// File: tb/tb_exe_forward_buffer.sv
// tb_exe_forward_buffer: directed plan plus randomized traffic against a slot-history reference model
module tb_exe_forward_buffer;
  logic        CLK = 1'b0, RESET = 1'b1;
  logic        advance, flush, push_write, push_pending, result_valid, fill_valid;
  logic [4:0]  push_reg, fill_reg;
  logic [31:0] result_data, fill_data, rf_a, rf_b;
  logic [1:0]  sel_a, sel_b, sel_mem;
  logic [31:0] operand_a, operand_b, store_data;
  logic        op_valid, fwd_hazard;
  logic [4:0]  hist_reg1, hist_reg2, hist_reg3;
  int n_chk = 0, n_fail = 0;

  typedef struct {logic [4:0] r; logic [31:0] d; logic p;} slot_t;
  slot_t m [3];
  logic [31:0] ea, eb, em;
  logic        ev, eh;

  exe_forward_buffer #(.DATA_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .advance(advance), .flush(flush),
    .push_write(push_write), .push_reg(push_reg), .push_pending(push_pending),
    .result_valid(result_valid), .result_data(result_data),
    .fill_valid(fill_valid), .fill_reg(fill_reg), .fill_data(fill_data),
    .sel_a(sel_a), .sel_b(sel_b), .sel_mem(sel_mem), .rf_a(rf_a), .rf_b(rf_b),
    .operand_a(operand_a), .operand_b(operand_b), .store_data(store_data),
    .op_valid(op_valid), .fwd_hazard(fwd_hazard),
    .hist_reg1(hist_reg1), .hist_reg2(hist_reg2), .hist_reg3(hist_reg3)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m[i] = '{r: 5'd0, d: 32'd0, p: 1'b0};
    ea = 0; eb = 0; em = 0; ev = 0; eh = 0;
  endtask

  task automatic idle();
    advance = 0; flush = 0; push_write = 0; push_pending = 0; push_reg = 0;
    result_valid = 0; result_data = 0; fill_valid = 0; fill_reg = 0; fill_data = 0;
    sel_a = 0; sel_b = 0; sel_mem = 0; rf_a = 0; rf_b = 0;
  endtask

  // value an instruction would see from history position k (1 = PC-4), after same-edge writes in t
  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rf, input slot_t t [3]);
    if (s == 0 || t[s-1].r == 0) return rf;
    return t[s-1].d;
  endfunction

  function automatic logic stalls(input logic [1:0] s, input slot_t t [3]);
    return s != 0 && t[s-1].r != 0 && t[s-1].p;
  endfunction

  task automatic model_edge();
    slot_t t [3];
    bit found = 0;
    if (flush) begin
      for (int i = 0; i < 3; i++) m[i] = '{r: 5'd0, d: 32'd0, p: 1'b0};
      ev = 0; eh = 0;
      return;
    end
    t = m;
    if (result_valid && m[0].r != 0) begin t[0].d = result_data; t[0].p = 0; end
    for (int i = 0; i < 3; i++)
      if (!found && fill_valid && m[i].p && m[i].r == fill_reg) begin
        t[i].d = fill_data; t[i].p = 0; found = 1;
      end
    if (advance) begin
      ea = pick(sel_a, rf_a, t);
      eb = pick(sel_b, rf_b, t);
      em = pick(sel_mem, rf_b, t);
      eh = stalls(sel_a, t) || stalls(sel_b, t) || stalls(sel_mem, t);
      ev = 1;
      m[2] = t[1];
      m[1] = t[0];
      m[0].r = (push_write && push_reg != 0) ? push_reg : 5'd0;
      m[0].d = 0;
      m[0].p = push_write && push_pending && push_reg != 0;
    end else m = t;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a"}, operand_a, ea);
    chk({tag, ".b"}, operand_b, eb);
    chk({tag, ".st"}, store_data, em);
    chk({tag, ".v"}, {31'd0, op_valid}, {31'd0, ev});
    chk({tag, ".hz"}, {31'd0, fwd_hazard}, {31'd0, eh});
    chk({tag, ".h1"}, {27'd0, hist_reg1}, {27'd0, m[0].r});
    chk({tag, ".h2"}, {27'd0, hist_reg2}, {27'd0, m[1].r});
    chk({tag, ".h3"}, {27'd0, hist_reg3}, {27'd0, m[2].r});
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    check_all(tag);
    idle();
  endtask

  task automatic push(input logic [4:0] r, input logic pend);
    advance = 1; push_write = 1; push_reg = r; push_pending = pend;
    step("push");
  endtask

  initial begin
    idle();
    model_reset();
    #12;
    check_all("reset");
    @(negedge CLK);
    RESET = 0;

    push(5'd5, 0);
    result_valid = 1; result_data = 32'hAA;
    step("res5");
    chk("t1.hist1", {27'd0, hist_reg1}, 32'd5);
    advance = 1; sel_a = 1; rf_a = 32'h11;
    step("t1.fwd");
    chk("t1.opa", operand_a, 32'hAA);
    chk("t1.valid", {31'd0, op_valid}, 32'd1);

    push(5'd3, 0); result_valid = 1; result_data = 32'h30; step("res3");
    push(5'd4, 0); result_valid = 1; result_data = 32'h40; step("res4");
    push(5'd6, 0); result_valid = 1; result_data = 32'h60; step("res6");
    chk("t2.hist", {17'd0, hist_reg1, hist_reg2, hist_reg3}, {17'd0, 5'd6, 5'd4, 5'd3});
    advance = 1; sel_a = 3; sel_b = 2; rf_a = 32'h1; rf_b = 32'h2;
    step("t2.fwd");
    chk("t2.opa", operand_a, 32'h30);
    chk("t2.opb", operand_b, 32'h40);

    push(5'd7, 1);
    advance = 1; sel_b = 1; rf_b = 32'h99;
    step("t3.stall");
    chk("t3.hazard", {31'd0, fwd_hazard}, 32'd1);
    push(5'd7, 1);
    advance = 1; sel_b = 1; rf_b = 32'h99; fill_valid = 1; fill_reg = 7; fill_data = 32'h77;
    step("t3.fill");
    chk("t3.opb", operand_b, 32'h77);
    chk("t3.nohazard", {31'd0, fwd_hazard}, 32'd0);

    push(5'd0, 0);
    chk("t4.hist1", {27'd0, hist_reg1}, 32'd0);
    advance = 1; sel_a = 1; rf_a = 32'h55;
    step("t4.r0");
    chk("t4.opa", operand_a, 32'h55);

    push(5'd1, 1); push(5'd2, 0); push(5'd3, 1);
    advance = 1; flush = 1; sel_a = 1;
    step("t5.flush");
    chk("t5.hist", {17'd0, hist_reg1, hist_reg2, hist_reg3}, 32'd0);
    chk("t5.valid", {31'd0, op_valid}, 32'd0);
    chk("t5.hazard", {31'd0, fwd_hazard}, 32'd0);

    for (int n = 0; n < 500; n++) begin
      advance = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 19) == 0;
      push_write = $urandom_range(0, 3) != 0;
      push_reg = 5'($urandom_range(0, 7));
      push_pending = $urandom_range(0, 2) == 0;
      result_valid = $urandom_range(0, 1);
      result_data = $urandom;
      fill_valid = $urandom_range(0, 2) == 0;
      fill_reg = $urandom_range(0, 1) ? m[$urandom_range(0, 2)].r : 5'($urandom_range(0, 7));
      fill_data = $urandom;
      sel_a = 2'($urandom_range(0, 3));
      sel_b = 2'($urandom_range(0, 3));
      sel_mem = 2'($urandom_range(0, 3));
      rf_a = $urandom;
      rf_b = $urandom;
      step("rnd");
    end

    push(5'd9, 0); push(5'd10, 1); push(5'd11, 0);
    chk("t6.pre", {31'd0, op_valid}, 32'd1);
    #2;
    RESET = 1;
    model_reset();
    #1;
    check_all("t6.async");
    @(negedge CLK);
    RESET = 0;

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
